// File: rtl/ball_pkg.sv
// Shared constants and FSM state type for the ball sprite motion path.
package ball_pkg;
  localparam int unsigned POS_W    = 10;
  localparam int unsigned SPEED_W  = 3;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned RADIUS   = 100;
  localparam int unsigned START_X  = 320;
  localparam int unsigned START_Y  = 240;

  typedef enum logic [1:0] {WAIT, MOVE_X, MOVE_Y, DONE} state_t;
endpackage

// File: rtl/ball_motion_sequencer_if.sv
// Control/status bundle between the raster timing, the motion sequencer and the renderer.
interface ball_motion_sequencer_if;
  logic [ball_pkg::POS_W-1:0]   hpos;
  logic [ball_pkg::POS_W-1:0]   vpos;
  logic [ball_pkg::SPEED_W-1:0] speed;
  logic                         pause;
  logic                         step_req;
  logic                         step_ack;
  logic [ball_pkg::POS_W-1:0]   ball_x;
  logic [ball_pkg::POS_W-1:0]   ball_y;
  logic                         dir_x;
  logic                         dir_y;
  logic                         bounce;
  logic [7:0]                   frame_cnt;

  modport master (
    output hpos, vpos, speed, pause, step_req,
    input  step_ack, ball_x, ball_y, dir_x, dir_y, bounce, frame_cnt
  );

  modport slave (
    input  hpos, vpos, speed, pause, step_req,
    output step_ack, ball_x, ball_y, dir_x, dir_y, bounce, frame_cnt
  );
endinterface

// File: rtl/ball_motion_sequencer_axis_step.sv
// One-axis position advance with reflection at [lo, hi]; purely combinational,
// shared between x and y by the sequencer.
module axis_step
  import ball_pkg::*;
(
  input  logic [POS_W-1:0]   p,
  input  logic               dir,
  input  logic [SPEED_W-1:0] speed,
  input  logic [POS_W-1:0]   lo,
  input  logic [POS_W-1:0]   hi,
  output logic [POS_W-1:0]   p_next,
  output logic               dir_next,
  output logic               hit
);
  logic [POS_W:0] speed_ext;
  logic [POS_W:0] sum;
  logic [POS_W:0] floor_lim;

  assign speed_ext = {{(POS_W+1-SPEED_W){1'b0}}, speed};
  assign sum       = {1'b0, p} + speed_ext;
  assign floor_lim = {1'b0, lo} + speed_ext;

  always_comb begin
    p_next   = p;
    dir_next = dir;
    hit      = 1'b0;
    // A zero speed never reflects, even when parked exactly on a limit.
    if (speed != '0) begin
      if (dir) begin
        if (sum >= {1'b0, hi}) begin
          p_next   = hi;
          dir_next = 1'b0;
          hit      = 1'b1;
        end else begin
          p_next = sum[POS_W-1:0];
        end
      end else begin
        if ({1'b0, p} < floor_lim) begin
          p_next   = lo;
          dir_next = 1'b1;
          hit      = 1'b1;
        end else begin
          p_next = p - speed_ext[POS_W-1:0];
        end
      end
    end
  end
endmodule

// File: rtl/ball_motion_sequencer.sv
// Once-per-frame ball centre update during vertical blanking, with pause and
// req/ack single-step; x and y share one axis_step across two FSM states.
module ball_motion_sequencer #(
  parameter int unsigned H_ACTIVE = ball_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = ball_pkg::V_ACTIVE,
  parameter int unsigned RADIUS   = ball_pkg::RADIUS,
  parameter int unsigned START_X  = ball_pkg::START_X,
  parameter int unsigned START_Y  = ball_pkg::START_Y
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ball_motion_sequencer_if.slave   bus
);
  import ball_pkg::*;

  localparam logic [POS_W-1:0] LO   = POS_W'(RADIUS);
  localparam logic [POS_W-1:0] X_HI = POS_W'(H_ACTIVE - RADIUS);
  localparam logic [POS_W-1:0] Y_HI = POS_W'(V_ACTIVE - RADIUS);
  localparam logic [POS_W-1:0] V_FS = POS_W'(V_ACTIVE);

  state_t               state_q, state_d;
  logic [POS_W-1:0]     x_q, x_d, y_q, y_d;
  logic                 dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic                 step_armed_q, step_armed_d;
  logic                 step_q, step_d;
  logic                 step_ack_q, step_ack_d;
  logic                 bounce_q, bounce_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;

  logic                 frame_start;
  logic                 take_step;
  logic [POS_W-1:0]     ax_p, ax_hi, ax_p_next;
  logic [SPEED_W-1:0]   ax_speed;
  logic                 ax_dir, ax_dir_next, ax_hit;

  assign frame_start = (bus.hpos == '0) && (bus.vpos == V_FS);
  assign take_step   = bus.pause && bus.step_req && step_armed_q;

  // x uses the live speed (latched this cycle); y reuses the latched copy.
  always_comb begin
    if (state_q == MOVE_Y) begin
      ax_p     = y_q;
      ax_dir   = dir_y_q;
      ax_speed = speed_q;
      ax_hi    = Y_HI;
    end else begin
      ax_p     = x_q;
      ax_dir   = dir_x_q;
      ax_speed = bus.speed;
      ax_hi    = X_HI;
    end
  end

  axis_step u_axis_step (
    .p        (ax_p),
    .dir      (ax_dir),
    .speed    (ax_speed),
    .lo       (LO),
    .hi       (ax_hi),
    .p_next   (ax_p_next),
    .dir_next (ax_dir_next),
    .hit      (ax_hit)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    speed_d      = speed_q;
    step_d       = step_q;
    step_ack_d   = 1'b0;
    bounce_d     = 1'b0;
    step_armed_d = bus.step_req ? step_armed_q : 1'b1;
    frame_cnt_d  = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;

    case (state_q)
      WAIT: begin
        if (frame_start && (!bus.pause || take_step)) begin
          state_d = MOVE_X;
          step_d  = bus.pause;
          if (bus.pause) step_armed_d = 1'b0;
        end
      end
      MOVE_X: begin
        x_d      = ax_p_next;
        dir_x_d  = ax_dir_next;
        bounce_d = ax_hit;
        speed_d  = bus.speed;
        state_d  = MOVE_Y;
      end
      MOVE_Y: begin
        y_d      = ax_p_next;
        dir_y_d  = ax_dir_next;
        bounce_d = ax_hit;
        state_d  = DONE;
      end
      DONE: begin
        step_ack_d = step_q;
        state_d    = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WAIT;
      x_q          <= POS_W'(START_X);
      y_q          <= POS_W'(START_Y);
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      speed_q      <= '0;
      step_armed_q <= 1'b1;
      step_q       <= 1'b0;
      step_ack_q   <= 1'b0;
      bounce_q     <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      speed_q      <= speed_d;
      step_armed_q <= step_armed_d;
      step_q       <= step_d;
      step_ack_q   <= step_ack_d;
      bounce_q     <= bounce_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.ball_x    = x_q;
  assign bus.ball_y    = y_q;
  assign bus.dir_x     = dir_x_q;
  assign bus.dir_y     = dir_y_q;
  assign bus.step_ack  = step_ack_q;
  assign bus.bounce    = bounce_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_ball_motion_sequencer.sv
// Bench for ball_motion_sequencer: two instances (default start and a start parked on
// the x/y limits) share one stimulus; a frame-level model feeds per-instance queues.
module tb_ball_motion_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ball_motion_sequencer_if if_a ();
  ball_motion_sequencer_if if_b ();

  assign if_b.hpos     = if_a.hpos;
  assign if_b.vpos     = if_a.vpos;
  assign if_b.speed    = if_a.speed;
  assign if_b.pause    = if_a.pause;
  assign if_b.step_req = if_a.step_req;

  ball_motion_sequencer dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  ball_motion_sequencer #(.START_X(540), .START_Y(100)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  typedef struct {
    int x; int y; bit dx; bit dy; int fc; int nb; int ack;
  } exp_t;

  exp_t q_exp[2][$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int   mx[2], my[2];
  bit   mdx[2], mdy[2];
  int   mfc;
  bit   marmed;

  int   start_x[2] = '{320, 540};
  int   start_y[2] = '{240, 100};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic axis_model(input int p, input bit d, input int s, input int hi,
                            output int p_o, output bit d_o, output bit h);
    p_o = p; d_o = d; h = 1'b0;
    if (s != 0) begin
      if (d) begin
        if (p + s >= hi) begin p_o = hi; d_o = 1'b0; h = 1'b1; end
        else p_o = p + s;
      end else begin
        if (p - s < 100) begin p_o = 100; d_o = 1'b1; h = 1'b1; end
        else p_o = p - s;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx[k] = start_x[k]; my[k] = start_y[k]; mdx[k] = 1'b1; mdy[k] = 1'b1;
    end
    mfc = 0;
    marmed = 1'b1;
  endtask

  task automatic get_dut(input int k, output int x, output int y, output bit dx, output bit dy,
                         output int fc, output bit b, output bit ack);
    if (k == 0) begin
      x = if_a.ball_x; y = if_a.ball_y; dx = if_a.dir_x; dy = if_a.dir_y;
      fc = if_a.frame_cnt; b = if_a.bounce; ack = if_a.step_ack;
    end else begin
      x = if_b.ball_x; y = if_b.ball_y; dx = if_b.dir_x; dy = if_b.dir_y;
      fc = if_b.frame_cnt; b = if_b.bounce; ack = if_b.step_ack;
    end
  endtask

  task automatic check_idle(input string tag);
    int x, y, fc; bit dx, dy, b, ack;
    for (int k = 0; k < 2; k++) begin
      get_dut(k, x, y, dx, dy, fc, b, ack);
      check($sformatf("%s[%0d].x", tag, k), x, mx[k]);
      check($sformatf("%s[%0d].y", tag, k), y, my[k]);
      check($sformatf("%s[%0d].dir_x", tag, k), dx, mdx[k]);
      check($sformatf("%s[%0d].dir_y", tag, k), dy, mdy[k]);
      check($sformatf("%s[%0d].frame_cnt", tag, k), fc, mfc);
      check($sformatf("%s[%0d].bounce", tag, k), b, 0);
      check($sformatf("%s[%0d].step_ack", tag, k), ack, 0);
    end
  endtask

  task automatic do_frame(input string tag);
    bit   taken, h, is_step;
    int   s;
    exp_t e;
    int   nb[2], na[2];
    int   x, y, fc; bit dx, dy, b, ack;

    if (!if_a.step_req) marmed = 1'b1;
    taken   = !if_a.pause || (if_a.step_req && marmed);
    is_step = taken && if_a.pause;
    if (is_step) marmed = 1'b0;
    mfc = (mfc + 1) % 256;
    s = int'(if_a.speed);
    for (int k = 0; k < 2; k++) begin
      e.nb = 0;
      if (taken) begin
        axis_model(mx[k], mdx[k], s, 540, mx[k], mdx[k], h);
        e.nb += int'(h);
        axis_model(my[k], mdy[k], s, 380, my[k], mdy[k], h);
        e.nb += int'(h);
      end
      e.x = mx[k]; e.y = my[k]; e.dx = mdx[k]; e.dy = mdy[k];
      e.fc = mfc; e.ack = int'(is_step);
      q_exp[k].push_back(e);
    end

    if_a.hpos = 10'd0; if_a.vpos = 10'd480;
    @(posedge clk); #1;
    if_a.hpos = 10'd3; if_a.vpos = 10'd7;
    nb = '{0, 0}; na = '{0, 0};
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 2; k++) begin
        get_dut(k, x, y, dx, dy, fc, b, ack);
        nb[k] += int'(b);
        na[k] += int'(ack);
      end
      @(posedge clk); #1;
    end

    for (int k = 0; k < 2; k++) begin
      if (q_exp[k].size() == 0) begin
        check($sformatf("%s[%0d].queue_empty", tag, k), 1, 0);
      end else begin
        e = q_exp[k].pop_front();
        get_dut(k, x, y, dx, dy, fc, b, ack);
        check($sformatf("%s[%0d].x", tag, k), x, e.x);
        check($sformatf("%s[%0d].y", tag, k), y, e.y);
        check($sformatf("%s[%0d].dir_x", tag, k), dx, e.dx);
        check($sformatf("%s[%0d].dir_y", tag, k), dy, e.dy);
        check($sformatf("%s[%0d].frame_cnt", tag, k), fc, e.fc);
        check($sformatf("%s[%0d].bounce_cycles", tag, k), nb[k], e.nb);
        check($sformatf("%s[%0d].step_ack_cycles", tag, k), na[k], e.ack);
      end
    end
  endtask

  initial begin
    int px; bit pdx, ph;

    if_a.hpos = 10'd3; if_a.vpos = 10'd7;
    if_a.speed = 3'd1; if_a.pause = 1'b0; if_a.step_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    check_idle("reset");

    do_frame("first");
    if_a.speed = 3'd0;
    repeat (2) do_frame("speed0");
    if_a.speed = 3'd7;
    repeat (40) do_frame("speed7");
    if_a.speed = 3'd3;
    repeat (15) do_frame("speed3");

    if_a.pause = 1'b1; if_a.speed = 3'd5;
    repeat (3) do_frame("paused");
    if_a.step_req = 1'b1;
    repeat (2) do_frame("step_held");
    if_a.step_req = 1'b0;
    do_frame("step_low");
    if_a.step_req = 1'b1;
    do_frame("step_again");
    if_a.pause = 1'b0;
    do_frame("req_unpaused");
    if_a.step_req = 1'b0; if_a.speed = 3'd6;
    repeat (3) do_frame("run6");

    for (int i = 0; i < 200; i++) begin
      if_a.speed    = 3'($urandom_range(0, 7));
      if_a.pause    = ($urandom_range(0, 3) == 0);
      if_a.step_req = 1'($urandom_range(0, 1));
      do_frame("random");
    end

    // Reset while in MOVE_Y: x has just moved, y not yet.
    if_a.pause = 1'b0; if_a.step_req = 1'b0; if_a.speed = 3'd4;
    axis_model(mx[0], mdx[0], 4, 540, px, pdx, ph);
    if_a.hpos = 10'd0; if_a.vpos = 10'd480;
    @(posedge clk); #1;
    if_a.hpos = 10'd3; if_a.vpos = 10'd7;
    @(posedge clk); #1;
    check("midreset.pre_x", if_a.ball_x, px);
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_idle("midreset");
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("midreset.no_ack", if_a.step_ack, 0);
    end
    check_idle("post_reset_idle");

    if_a.speed = 3'd2;
    do_frame("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
